kamus_fetch_queue: RTL and testbench
====================================

KAMUS_FETCH_QUEUE -- requirements
Module: kamus_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of queue entries (power of two, >= 2).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port flush_i  input  1  discard all queued entries (branch/jump redirect).
REQ-005 SHALL have port if_valid_i  input  1  fetch stage offers an entry.
REQ-006 SHALL have port if_pc_i  input  32  instruction address of the offered entry.
REQ-007 SHALL have port if_instr_i  input  32  instruction word of the offered entry.
REQ-008 SHALL have port if_ready_o  output  1  queue accepts an entry this cycle.
REQ-009 SHALL have port id_valid_o  output  1  head entry available to decode.
REQ-010 SHALL have port id_pc_o  output  32  head entry address.
REQ-011 SHALL have port id_instr_o  output  32  head entry instruction word.
REQ-012 SHALL have port id_ready_i  input  1  decode consumes the head entry this cycle.
REQ-013 SHALL have port count_o  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-014 Push SHALL occur when if_valid_i && if_ready_o && !flush_i; entry {if_pc_i, if_instr_i} written at tail, tail pointer advances.
REQ-015 Pop SHALL occur when id_valid_o && id_ready_i && !flush_i; head pointer advances.
REQ-016 if_ready_o SHALL equal (count_o != DEPTH), independent of id_ready_i and if_valid_i (no combinational ready path).
REQ-017 id_valid_o SHALL equal (count_o != 0); no bypass: an entry pushed in cycle N is first visible on id_* in cycle N+1.
REQ-018 id_pc_o/id_instr_o SHALL reflect the head entry when id_valid_o=1; when id_valid_o=0 they SHALL be 32'h0 and NOP (32'h00000013).
REQ-019 Simultaneous push and pop SHALL leave count_o unchanged and preserve order; allowed at any occupancy 1..DEPTH-1.
REQ-020 When full, a pop with if_valid_i=1 SHALL NOT push in the same cycle (if_ready_o=0); push accepted next cycle.
REQ-021 When empty, id_ready_i SHALL have no effect.
REQ-022 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count_o updates +1 push-only, -1 pop-only.
REQ-023 flush_i=1 SHALL in the next cycle yield count_o=0, pointers 0, id_valid_o=0, if_ready_o=1; any same-cycle push or pop is discarded.
REQ-024 flush_i SHALL take priority over push and pop; flush on an empty queue is harmless.
REQ-025 if_valid_i held while if_ready_o=0 SHALL NOT corrupt state; stored entries never change until popped or flushed.
REQ-026 Instruction words SHALL pass unmodified; the block performs no decoding.

Reset
REQ-027 rst_ni=0 at a rising edge SHALL set count_o=0, pointers 0, id_valid_o=0, if_ready_o=1, id_pc_o=32'h0, id_instr_o=32'h00000013.
REQ-028 Reset SHALL override flush_i, push and pop in the same cycle, including reset mid-operation with a full queue.
REQ-029 Entry storage SHALL NOT require reset; its contents are unobservable while invalid.

Structure
REQ-030 NOP constant (32'h00000013) and the fetch entry struct typedef {pc[31:0], instr[31:0]} SHALL live in shared package kamus_pkg.
REQ-031 Storage SHALL be a register array of DEPTH entries with explicit head/tail pointers and a count register; no sub-module is needed.
REQ-032 The block SHALL sit between kamus_IF and the decode stage; decode sees only id_* ports.

Verification
REQ-033 Reset: rst_ni=0 for 2 cycles with if_valid_i=1 -> count_o=0, id_valid_o=0, id_instr_o=32'h00000013, if_ready_o=1.
REQ-034 Fill/drain: push pc 0x0,0x4 with id_ready_i=0 -> count_o=2, if_ready_o=0; then id_ready_i=1 -> pops 0x0 then 0x4 in order, count_o returns 0.
REQ-035 Full with pop: queue full (0x0,0x4), if_valid_i=1 pc 0x8, id_ready_i=1 -> cycle pops 0x0, 0x8 not pushed; next cycle 0x8 accepted, order 0x4,0x8.
REQ-036 Streaming: if_valid_i=1 and id_ready_i=1 every cycle, pcs 0x0..0x3C -> id_pc_o sequence 0x0..0x3C one cycle later, count_o stays 1, pointers wrap with no loss.
REQ-037 Flush: queue holds 0x10,0x14, flush_i=1 with push 0x18 -> next cycle count_o=0, id_valid_o=0; push 0x100 afterward appears as head.
REQ-038 Reset mid-operation: full queue, rst_ni=0 for 1 cycle -> count_o=0, id_valid_o=0 next cycle; no stale entry emerges.

Source files
------------

// File: rtl/kamus_pkg.sv
// rtl/kamus_pkg.sv - shared types and constants for the kamus fetch/decode pipeline
package kamus_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Entry handed to decode when nothing is valid: address zero, canonical NOP.
    function automatic fetch_entry_t idle_entry();
        fetch_entry_t e;
        e.pc    = 32'h0;
        e.instr = NOP;
        return e;
    endfunction

endpackage

// File: rtl/kamus_fetch_queue.sv
// rtl/kamus_fetch_queue.sv - fetch-to-decode entry queue with flush and no bypass path
module kamus_fetch_queue
    import kamus_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       if_valid_i,
    input  logic [31:0]                if_pc_i,
    input  logic [31:0]                if_instr_i,
    output logic                       if_ready_o,
    output logic                       id_valid_o,
    output logic [31:0]                id_pc_o,
    output logic [31:0]                id_instr_o,
    input  logic                       id_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t             mem [DEPTH];
    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         tail;
    logic [CNT_W-1:0]         count;
    logic                     push;
    logic                     pop;
    fetch_entry_t             head_entry;

    // Ready and valid depend only on occupancy so no combinational path crosses the queue.
    assign if_ready_o = (count != FULL_CNT);
    assign id_valid_o = (count != '0);

    assign push = if_valid_i && if_ready_o && !flush_i;
    assign pop  = id_valid_o && id_ready_i && !flush_i;

    always_comb begin
        head_entry = idle_entry();
        if (id_valid_o) begin
            head_entry = mem[head];
        end
    end

    assign id_pc_o    = head_entry.pc;
    assign id_instr_o = head_entry.instr;
    assign count_o    = count;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage is never reset; contents are masked by id_valid_o until written.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            mem[tail] <= '{pc: if_pc_i, instr: if_instr_i};
        end
    end

endmodule

// File: tb/tb_kamus_fetch_queue.sv
// tb/tb_kamus_fetch_queue.sv - self-checking bench for kamus_fetch_queue against a queue model
module tb_kamus_fetch_queue;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             if_valid_i;
    logic [31:0]      if_pc_i;
    logic [31:0]      if_instr_i;
    logic             if_ready_o;
    logic             id_valid_o;
    logic [31:0]      id_pc_o;
    logic [31:0]      id_instr_o;
    logic             id_ready_i;
    logic [CNT_W-1:0] count_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] fq[$];

    kamus_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .if_valid_i (if_valid_i),
        .if_pc_i    (if_pc_i),
        .if_instr_i (if_instr_i),
        .if_ready_o (if_ready_o),
        .id_valid_o (id_valid_o),
        .id_pc_o    (id_pc_o),
        .id_instr_o (id_instr_o),
        .id_ready_i (id_ready_i),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    // Expected {count, valid, ready, pc, instr} derived from the model queue.
    function automatic logic [67:0] expected_outputs();
        logic [31:0] pc;
        logic [31:0] instr;
        int          n;
        n     = fq.size();
        pc    = (n != 0) ? fq[0][63:32] : 32'h0;
        instr = (n != 0) ? fq[0][31:0]  : NOP_W;
        return {CNT_W'(n), (n != 0), (n != DEPTH), pc, instr};
    endfunction

    function automatic logic [67:0] observed_outputs();
        return {count_o, id_valid_o, if_ready_o, id_pc_o, id_instr_o};
    endfunction

    // Advance one clock and apply the queue rules to the model.
    task automatic tick();
        bit will_push;
        bit will_pop;
        will_push = if_valid_i && (fq.size() != DEPTH) && !flush_i;
        will_pop  = id_ready_i && (fq.size() != 0) && !flush_i;
        @(posedge clk);
        if (!rst_ni || flush_i) begin
            fq.delete();
        end else begin
            if (will_pop)  void'(fq.pop_front());
            if (will_push) fq.push_back({if_pc_i, if_instr_i});
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst_ni     = 1'b1;
        flush_i    = 1'b0;
        if_valid_i = 1'b0;
        if_pc_i    = 32'h0;
        if_instr_i = 32'h0;
        id_ready_i = 1'b0;
    endtask

    task automatic offer(input logic [31:0] pc);
        if_valid_i = 1'b1;
        if_pc_i    = pc;
        if_instr_i = $urandom;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        offer(32'h40);
        id_ready_i = 1'b1;
        tick();
        tick();
        rst_ni = 1'b1;
        if_valid_i = 1'b0;
        #1;
        n_checks++;
        if ({count_o, id_valid_o, if_ready_o, id_pc_o, id_instr_o} !==
            {CNT_W'(0), 1'b0, 1'b1, 32'h0, NOP_W}) begin
            n_fail++;
            $display("FAIL reset_state: got cnt=%0d v=%b r=%b pc=%h ins=%h, want cnt=0 v=0 r=1 pc=0 ins=00000013",
                     count_o, id_valid_o, if_ready_o, id_pc_o, id_instr_o);
        end
    endtask

    task automatic fill_two(input logic [31:0] pc0, input logic [31:0] pc1);
        id_ready_i = 1'b0;
        offer(pc0);
        tick();
        offer(pc1);
        tick();
        if_valid_i = 1'b0;
        #1;
    endtask

    task automatic test_fill_drain();
        idle_inputs();
        fill_two(32'h0, 32'h4);
        n_checks++;
        if (count_o !== CNT_W'(2) || if_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got cnt=%0d r=%b, want cnt=2 r=0", count_o, if_ready_o);
        end
        id_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (id_valid_o !== 1'b1 || id_pc_o !== 32'(4 * i) || observed_outputs() !== expected_outputs()) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got v=%b pc=%h ins=%h, want v=1 pc=%h ins=%h",
                         i, id_valid_o, id_pc_o, id_instr_o, 32'(4 * i), fq[0][31:0]);
            end
            tick();
        end
        n_checks++;
        if (count_o !== CNT_W'(0) || id_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: got cnt=%0d v=%b, want cnt=0 v=0", count_o, id_valid_o);
        end
        id_ready_i = 1'b0;
    endtask

    task automatic test_full_with_pop();
        idle_inputs();
        fill_two(32'h0, 32'h4);
        offer(32'h8);
        id_ready_i = 1'b1;
        #1;
        n_checks++;
        if (if_ready_o !== 1'b0 || id_pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL full_pop_pre: got r=%b pc=%h, want r=0 pc=0", if_ready_o, id_pc_o);
        end
        tick();
        n_checks++;
        if (count_o !== CNT_W'(1) || id_pc_o !== 32'h4 || if_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop_nopush: got cnt=%0d pc=%h r=%b, want cnt=1 pc=4 r=1", count_o, id_pc_o, if_ready_o);
        end
        tick();
        if_valid_i = 1'b0;
        id_ready_i = 1'b0;
        #1;
        n_checks++;
        if (count_o !== CNT_W'(1) || id_pc_o !== 32'h8 || observed_outputs() !== expected_outputs()) begin
            n_fail++;
            $display("FAIL full_pop_accept: got cnt=%0d pc=%h ins=%h, want cnt=1 pc=8 ins=%h",
                     count_o, id_pc_o, id_instr_o, fq[0][31:0]);
        end
        id_ready_i = 1'b1;
        tick();
        id_ready_i = 1'b0;
    endtask

    task automatic test_streaming();
        int bad;
        idle_inputs();
        bad = 0;
        id_ready_i = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) offer(32'(4 * i));
            else if_valid_i = 1'b0;
            #1;
            if (i > 0) begin
                n_checks++;
                if (id_pc_o !== 32'(4 * (i - 1)) || count_o !== CNT_W'(1) ||
                    observed_outputs() !== expected_outputs()) begin
                    n_fail++;
                    $display("FAIL stream[%0d]: got pc=%h cnt=%0d, want pc=%h cnt=1",
                             i, id_pc_o, count_o, 32'(4 * (i - 1)));
                end
            end
            tick();
        end
        n_checks++;
        if (count_o !== CNT_W'(0)) begin
            n_fail++;
            $display("FAIL stream_end: got cnt=%0d, want 0", count_o);
        end
        id_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        idle_inputs();
        fill_two(32'h10, 32'h14);
        offer(32'h18);
        flush_i = 1'b1;
        id_ready_i = 1'b1;
        tick();
        flush_i = 1'b0;
        if_valid_i = 1'b0;
        id_ready_i = 1'b0;
        #1;
        n_checks++;
        if (count_o !== CNT_W'(0) || id_valid_o !== 1'b0 || if_ready_o !== 1'b1 || id_instr_o !== NOP_W) begin
            n_fail++;
            $display("FAIL flush_clear: got cnt=%0d v=%b r=%b ins=%h, want cnt=0 v=0 r=1 ins=00000013",
                     count_o, id_valid_o, if_ready_o, id_instr_o);
        end
        offer(32'h100);
        tick();
        if_valid_i = 1'b0;
        #1;
        n_checks++;
        if (id_pc_o !== 32'h100 || count_o !== CNT_W'(1) || observed_outputs() !== expected_outputs()) begin
            n_fail++;
            $display("FAIL flush_refill: got pc=%h cnt=%0d, want pc=100 cnt=1", id_pc_o, count_o);
        end
        flush_i = 1'b1;
        tick();
        tick();
        flush_i = 1'b0;
        #1;
        n_checks++;
        if (count_o !== CNT_W'(0) || id_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty: got cnt=%0d v=%b, want cnt=0 v=0", count_o, id_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        fill_two(32'h20, 32'h24);
        rst_ni = 1'b0;
        offer(32'h28);
        id_ready_i = 1'b1;
        tick();
        rst_ni = 1'b1;
        if_valid_i = 1'b0;
        #1;
        n_checks++;
        if (count_o !== CNT_W'(0) || id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || if_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got cnt=%0d v=%b pc=%h r=%b, want cnt=0 v=0 pc=0 r=1",
                     count_o, id_valid_o, id_pc_o, if_ready_o);
        end
        tick();
        n_checks++;
        if (id_valid_o !== 1'b0 || count_o !== CNT_W'(0)) begin
            n_fail++;
            $display("FAIL reset_stale: got v=%b cnt=%0d pc=%h, want v=0 cnt=0", id_valid_o, count_o, id_pc_o);
        end
        id_ready_i = 1'b0;
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            rst_ni     = ($urandom_range(0, 49) != 0);
            flush_i    = ($urandom_range(0, 19) == 0);
            if_valid_i = $urandom_range(0, 3) != 0;
            if_pc_i    = $urandom & 32'hFFFF_FFFC;
            if_instr_i = $urandom;
            id_ready_i = $urandom_range(0, 2) != 0;
            #1;
            n_checks++;
            if (observed_outputs() !== expected_outputs()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h, want %h", i, observed_outputs(), expected_outputs());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill_drain();
        test_full_with_pop();
        test_streaming();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
